// File: rtl/cr_fifoctrl_rmtsync_if.sv
// Bundle of pointer inputs and status outputs for the remote Gray-pointer
// receiver. The master side drives the pointers and the error clear; the
// slave side (the receiver) returns the synchronised pointer, the level and
// the status flags.
interface cr_fifoctrl_rmtsync_if #(
  parameter int ADDR_SIZE = 3
);
  localparam int PW = ADDR_SIZE + 1;

  logic [PW-1:0] rmt_ptr;
  logic [PW-1:0] lcl_ptr;
  logic          err_clr;
  logic [PW-1:0] sync_ptr;
  logic [PW-1:0] sync_bin;
  logic [PW-1:0] level;
  logic          almost_flag;
  logic          valid;
  logic          gray_err;
  logic          level_err;

  modport master (
    output rmt_ptr, lcl_ptr, err_clr,
    input  sync_ptr, sync_bin, level, almost_flag, valid, gray_err, level_err
  );

  modport slave (
    input  rmt_ptr, lcl_ptr, err_clr,
    output sync_ptr, sync_bin, level, almost_flag, valid, gray_err, level_err
  );
endinterface

// File: rtl/cr_fifoctrl_rmtsync.sv
// Receiving end of a Gray-pointer clock-domain crossing for a FIFO
// controller side. The remote Gray pointer goes through a plain flop chain,
// is checked for legal single-bit steps, is converted to binary together
// with the local pointer, and a registered fill level plus almost flag is
// produced. CTRL_TYPE 0 is the write side (almost-full), 1 the read side
// (almost-empty).
module cr_fifoctrl_rmtsync #(
  parameter int ADDR_SIZE   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int ALMOST_SIZE = 2,
  parameter int CTRL_TYPE   = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  cr_fifoctrl_rmtsync_if.slave     bus
);
  localparam int PW    = ADDR_SIZE + 1;
  localparam int DEPTH = 1 << ADDR_SIZE;

  localparam logic [PW-1:0] DEPTH_L    = PW'(DEPTH);
  localparam logic [PW-1:0] FULL_THR   = PW'(DEPTH - ALMOST_SIZE);
  localparam logic [PW-1:0] EMPTY_THR  = PW'(ALMOST_SIZE);
  localparam logic [2:0]    FLUSH_LAST = 3'(SYNC_STAGES);
  localparam logic          ALMOST_RST = (CTRL_TYPE == 1) ? 1'b1 : 1'b0;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit is set (clearing the lowest set bit leaves something).
  function automatic logic multi_bit(input logic [PW-1:0] d);
    return (d & (d - {{(PW-1){1'b0}}, 1'b1})) != {PW{1'b0}};
  endfunction

  logic [PW-1:0] sync_q [SYNC_STAGES];
  logic [PW-1:0] prev_sync_r;
  logic [PW-1:0] sync_bin_r;
  logic [PW-1:0] level_r;
  logic          almost_r;
  logic [2:0]    flush_cnt_r;
  logic          valid_r;
  logic          gray_err_r;
  logic          level_err_r;

  logic [PW-1:0] sync_ptr_s;
  logic [PW-1:0] sync_bin_s;
  logic [PW-1:0] lcl_bin_s;
  logic [PW-1:0] level_s;
  logic          almost_s;
  logic          gray_set_s;
  logic          level_set_s;

  assign sync_ptr_s = sync_q[SYNC_STAGES-1];

  // Pure flop chain for the asynchronous remote pointer; no logic between stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= {PW{1'b0}};
      end
    end else begin
      sync_q[0] <= bus.rmt_ptr;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Next-state level, almost flag and error events; modulo subtraction absorbs pointer wrap.
  always_comb begin
    sync_bin_s  = gray2bin(sync_ptr_s);
    lcl_bin_s   = gray2bin(bus.lcl_ptr);
    level_s     = {PW{1'b0}};
    almost_s    = 1'b0;
    if (CTRL_TYPE == 0) begin
      level_s  = lcl_bin_s - sync_bin_s;
      almost_s = (level_s >= FULL_THR);
    end else begin
      level_s  = sync_bin_s - lcl_bin_s;
      almost_s = (level_s <= EMPTY_THR);
    end
    gray_set_s  = valid_r & multi_bit(sync_ptr_s ^ prev_sync_r);
    level_set_s = (level_s > DEPTH_L);
  end

  // Second stage: binary pointer, level and almost flag registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_sync_r <= {PW{1'b0}};
      sync_bin_r  <= {PW{1'b0}};
      level_r     <= {PW{1'b0}};
      almost_r    <= ALMOST_RST;
    end else begin
      prev_sync_r <= sync_ptr_s;
      sync_bin_r  <= sync_bin_s;
      level_r     <= level_s;
      almost_r    <= almost_s;
    end
  end

  // Valid rises once the synchroniser and the second stage have been flushed after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_cnt_r <= 3'd0;
      valid_r     <= 1'b0;
    end else if (!valid_r) begin
      if (flush_cnt_r == FLUSH_LAST) begin
        valid_r <= 1'b1;
      end else begin
        flush_cnt_r <= flush_cnt_r + 3'd1;
      end
    end else begin
      valid_r <= 1'b1;
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gray_err_r  <= 1'b0;
      level_err_r <= 1'b0;
    end else begin
      gray_err_r  <= gray_set_s  | (gray_err_r  & ~bus.err_clr);
      level_err_r <= level_set_s | (level_err_r & ~bus.err_clr);
    end
  end

  assign bus.sync_ptr    = sync_ptr_s;
  assign bus.sync_bin    = sync_bin_r;
  assign bus.level       = level_r;
  assign bus.almost_flag = almost_r;
  assign bus.valid       = valid_r;
  assign bus.gray_err    = gray_err_r;
  assign bus.level_err   = level_err_r;
endmodule

// File: tb/tb_cr_fifoctrl_rmtsync.sv
// Directed bench for cr_fifoctrl_rmtsync with ADDR_SIZE=3 (D=8), two sync
// stages and an almost threshold of 2. One instance per side: dut0 is the
// write side, dut1 the read side.
module tb_cr_fifoctrl_rmtsync;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cr_fifoctrl_rmtsync_if #(.ADDR_SIZE(3)) bus0 ();
  cr_fifoctrl_rmtsync_if #(.ADDR_SIZE(3)) bus1 ();

  cr_fifoctrl_rmtsync #(.ADDR_SIZE(3), .SYNC_STAGES(2), .ALMOST_SIZE(2), .CTRL_TYPE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  cr_fifoctrl_rmtsync #(.ADDR_SIZE(3), .SYNC_STAGES(2), .ALMOST_SIZE(2), .CTRL_TYPE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  // One clock edge, then step off it so sampling and driving avoid the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus0.rmt_ptr = 4'b0000; bus0.lcl_ptr = 4'b0000; bus0.err_clr = 1'b0;
    bus1.rmt_ptr = 4'b0000; bus1.lcl_ptr = 4'b0000; bus1.err_clr = 1'b0;
    tick(); tick();
    total++; if (bus0.sync_ptr !== 4'b0000) begin bad++; $display("FAIL rst_sync_ptr got=%b exp=0000", bus0.sync_ptr); end
    total++; if (bus0.sync_bin !== 4'b0000) begin bad++; $display("FAIL rst_sync_bin got=%b exp=0000", bus0.sync_bin); end
    total++; if (bus0.level !== 4'b0000) begin bad++; $display("FAIL rst_level got=%b exp=0000", bus0.level); end
    total++; if (bus0.almost_flag !== 1'b0) begin bad++; $display("FAIL rst_almost0 got=%b exp=0", bus0.almost_flag); end
    total++; if (bus1.almost_flag !== 1'b1) begin bad++; $display("FAIL rst_almost1 got=%b exp=1", bus1.almost_flag); end
    total++; if (bus0.valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", bus0.valid); end
    total++; if ({bus0.gray_err, bus0.level_err} !== 2'b00) begin bad++; $display("FAIL rst_errs got=%b exp=00", {bus0.gray_err, bus0.level_err}); end
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++; if (bus0.valid !== (e == 3)) begin bad++; $display("FAIL valid_rise0 edge=%0d got=%b exp=%b", e, bus0.valid, (e == 3)); end
      total++; if (bus1.valid !== (e == 3)) begin bad++; $display("FAIL valid_rise1 edge=%0d got=%b exp=%b", e, bus1.valid, (e == 3)); end
      total++; if (bus1.almost_flag !== 1'b1) begin bad++; $display("FAIL almost1_hold edge=%0d got=%b exp=1", e, bus1.almost_flag); end
    end
    total++; if (bus0.level !== 4'b0000) begin bad++; $display("FAIL post_rst_level got=%b exp=0000", bus0.level); end
    total++; if (bus0.almost_flag !== 1'b0) begin bad++; $display("FAIL post_rst_almost0 got=%b exp=0", bus0.almost_flag); end
  endtask

  task automatic test_fill();
    logic [3:0] gtab [6];
    logic [3:0] exp_level;
    logic       exp_almost;
    gtab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101};
    for (int k = 1; k <= 6; k++) begin
      bus0.lcl_ptr = gtab[k-1];
      tick();
      exp_level  = 4'(k);
      exp_almost = (k >= 6);
      total++; if (bus0.level !== exp_level) begin bad++; $display("FAIL fill_level k=%0d got=%0d exp=%0d", k, bus0.level, exp_level); end
      total++; if (bus0.almost_flag !== exp_almost) begin bad++; $display("FAIL fill_almost k=%0d got=%b exp=%b", k, bus0.almost_flag, exp_almost); end
    end
  endtask

  task automatic test_wrap();
    bus1.lcl_ptr = 4'b1001;
    bus1.rmt_ptr = 4'b0001;
    tick(); tick(); tick();
    total++; if (bus1.sync_ptr !== 4'b0001) begin bad++; $display("FAIL wrap_sync_ptr got=%b exp=0001", bus1.sync_ptr); end
    total++; if (bus1.sync_bin !== 4'b0001) begin bad++; $display("FAIL wrap_sync_bin got=%b exp=0001", bus1.sync_bin); end
    total++; if (bus1.level !== 4'd3) begin bad++; $display("FAIL wrap_level got=%0d exp=3", bus1.level); end
    total++; if (bus1.almost_flag !== 1'b0) begin bad++; $display("FAIL wrap_almost got=%b exp=0", bus1.almost_flag); end
    total++; if (bus1.gray_err !== 1'b0) begin bad++; $display("FAIL wrap_gray_err got=%b exp=0", bus1.gray_err); end
  endtask

  task automatic test_latency();
    bus0.rmt_ptr = 4'b0001;
    tick();
    total++; if (bus0.sync_ptr !== 4'b0000) begin bad++; $display("FAIL lat_n1_sync_ptr got=%b exp=0000", bus0.sync_ptr); end
    tick();
    total++; if (bus0.sync_ptr !== 4'b0001) begin bad++; $display("FAIL lat_n2_sync_ptr got=%b exp=0001", bus0.sync_ptr); end
    total++; if (bus0.sync_bin !== 4'b0000) begin bad++; $display("FAIL lat_n2_sync_bin got=%b exp=0000", bus0.sync_bin); end
    total++; if (bus0.level !== 4'd6) begin bad++; $display("FAIL lat_n2_level got=%0d exp=6", bus0.level); end
    tick();
    total++; if (bus0.sync_bin !== 4'b0001) begin bad++; $display("FAIL lat_n3_sync_bin got=%b exp=0001", bus0.sync_bin); end
    total++; if (bus0.level !== 4'd5) begin bad++; $display("FAIL lat_n3_level got=%0d exp=5", bus0.level); end
    total++; if (bus0.almost_flag !== 1'b0) begin bad++; $display("FAIL lat_n3_almost got=%b exp=0", bus0.almost_flag); end
  endtask

  task automatic test_gray_err();
    bus0.rmt_ptr = 4'b0000;
    tick(); tick(); tick();
    total++; if (bus0.gray_err !== 1'b0) begin bad++; $display("FAIL gerr_legal got=%b exp=0", bus0.gray_err); end
    bus0.rmt_ptr = 4'b0011;
    tick(); tick();
    total++; if (bus0.sync_ptr !== 4'b0011) begin bad++; $display("FAIL gerr_sync_ptr got=%b exp=0011", bus0.sync_ptr); end
    total++; if (bus0.gray_err !== 1'b0) begin bad++; $display("FAIL gerr_early got=%b exp=0", bus0.gray_err); end
    tick();
    total++; if (bus0.gray_err !== 1'b1) begin bad++; $display("FAIL gerr_set got=%b exp=1", bus0.gray_err); end
    tick(); tick();
    total++; if (bus0.gray_err !== 1'b1) begin bad++; $display("FAIL gerr_sticky got=%b exp=1", bus0.gray_err); end
    bus0.err_clr = 1'b1;
    tick();
    bus0.err_clr = 1'b0;
    total++; if (bus0.gray_err !== 1'b0) begin bad++; $display("FAIL gerr_clear got=%b exp=0", bus0.gray_err); end
    bus0.rmt_ptr = 4'b0000;
    tick(); tick();
    total++; if (bus0.gray_err !== 1'b0) begin bad++; $display("FAIL gerr_pre_second got=%b exp=0", bus0.gray_err); end
    bus0.err_clr = 1'b1;
    tick();
    bus0.err_clr = 1'b0;
    total++; if (bus0.gray_err !== 1'b1) begin bad++; $display("FAIL gerr_set_wins got=%b exp=1", bus0.gray_err); end
    total++; if (bus0.level_err !== 1'b0) begin bad++; $display("FAIL gerr_level_err got=%b exp=0", bus0.level_err); end
  endtask

  task automatic test_level_err();
    bus0.lcl_ptr = 4'b1101;
    tick();
    total++; if (bus0.level !== 4'd9) begin bad++; $display("FAIL lerr_level got=%0d exp=9", bus0.level); end
    total++; if (bus0.level_err !== 1'b1) begin bad++; $display("FAIL lerr_set got=%b exp=1", bus0.level_err); end
    total++; if (bus0.almost_flag !== 1'b1) begin bad++; $display("FAIL lerr_almost got=%b exp=1", bus0.almost_flag); end
    tick();
    total++; if (bus0.level_err !== 1'b1) begin bad++; $display("FAIL lerr_sticky got=%b exp=1", bus0.level_err); end
  endtask

  task automatic test_mid_reset();
    #2;
    rst = 1'b1;
    #1;
    total++; if (bus0.level !== 4'b0000) begin bad++; $display("FAIL mrst_level got=%0d exp=0", bus0.level); end
    total++; if ({bus0.gray_err, bus0.level_err} !== 2'b00) begin bad++; $display("FAIL mrst_errs got=%b exp=00", {bus0.gray_err, bus0.level_err}); end
    total++; if (bus0.valid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b exp=0", bus0.valid); end
    total++; if (bus0.almost_flag !== 1'b0) begin bad++; $display("FAIL mrst_almost0 got=%b exp=0", bus0.almost_flag); end
    total++; if (bus1.sync_ptr !== 4'b0000) begin bad++; $display("FAIL mrst_sync_ptr1 got=%b exp=0000", bus1.sync_ptr); end
    total++; if (bus1.level !== 4'b0000) begin bad++; $display("FAIL mrst_level1 got=%0d exp=0", bus1.level); end
    total++; if (bus1.almost_flag !== 1'b1) begin bad++; $display("FAIL mrst_almost1 got=%b exp=1", bus1.almost_flag); end
    bus0.lcl_ptr = 4'b0000; bus0.rmt_ptr = 4'b0000;
    bus1.lcl_ptr = 4'b0000; bus1.rmt_ptr = 4'b0000;
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      total++; if (bus0.valid !== (e == 3)) begin bad++; $display("FAIL mrst_valid_rise edge=%0d got=%b exp=%b", e, bus0.valid, (e == 3)); end
    end
    total++; if (bus0.level_err !== 1'b0) begin bad++; $display("FAIL mrst_level_err got=%b exp=0", bus0.level_err); end
    total++; if (bus0.level !== 4'b0000) begin bad++; $display("FAIL mrst_level_after got=%0d exp=0", bus0.level); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_wrap();
    test_latency();
    test_gray_err();
    test_level_err();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cr_fifoctrl_rmtsync.md
Name: cr_fifoctrl_rmtsync

Overview:
- Receiving end of the Gray-pointer crossing used by the FIFO controller pointer trackers.
- Samples the remote domain's Gray pointer into the local clock through a synchroniser chain and checks that every sampled step is a legal Gray step.
- Converts both the synchronised remote pointer and the local Gray pointer to binary, and produces a registered fill level and almost flag.
- Instantiated once per FIFO side: on the write side it reports occupancy and almost-full, on the read side occupancy and almost-empty.

Parameters:
- pAddrSize, 3: memory address width; FIFO depth D = 2^pAddrSize; pointers are pAddrSize+1 bits.
- pSyncStages, 2: synchroniser flop stages on RmtPtr; legal range 2..4.
- pAlmostSize, 2: almost threshold in entries; legal range 0..D.
- pCtrlType, 0: side select. 0 = write side (local is write pointer); 1 = read side (local is read pointer).

Ports:
- Clk, in, 1: local clock.
- Rst, in, 1: asynchronous, active-high reset.
- RmtPtr, in, pAddrSize+1: Gray pointer from the remote clock domain, unsynchronised.
- LclPtr, in, pAddrSize+1: registered Gray pointer of the local domain.
- ErrClr, in, 1: clears the sticky error flags.
- SyncPtr, out, pAddrSize+1: synchronised remote Gray pointer (last sync stage).
- SyncBin, out, pAddrSize+1: registered binary of SyncPtr.
- Level, out, pAddrSize+1: registered occupancy, 0..D.
- AlmostFlag, out, 1: registered almost-full (type 0) or almost-empty (type 1).
- Valid, out, 1: outputs reflect a fully flushed synchroniser.
- GrayErr, out, 1: sticky; a non-Gray step was seen on SyncPtr.
- LevelErr, out, 1: sticky; the computed Level exceeded D.

Behaviour:
- Reset (async assert, sync deassert taken externally):
  - All sync stages, SyncPtr, SyncBin, Level, Valid, GrayErr and LevelErr are 0.
  - AlmostFlag resets to 0 for type 0 and to 1 for type 1.
- Sync chain:
  - s[0] <= RmtPtr, s[k] <= s[k-1], SyncPtr = s[pSyncStages-1].
  - Latency from a RmtPtr change to SyncPtr is pSyncStages cycles.
  - No logic is allowed between the sync stages.
- Stage 2 (registered, one cycle after SyncPtr):
  - SyncBin = gray2bin(SyncPtr).
  - lclBin = gray2bin(LclPtr).
  - Type 0: Level = (lclBin - SyncBin) mod 2^(pAddrSize+1).
  - Type 1: Level = (SyncBin - lclBin) mod 2^(pAddrSize+1).
  - All subtraction is modulo, pAddrSize+1 bits wide, so pointer wrap needs no special case.
- AlmostFlag is computed from the next Level value, registered alongside Level:
  - Type 0: AlmostFlag = (Level >= D - pAlmostSize).
  - Type 1: AlmostFlag = (Level <= pAlmostSize).
- Valid:
  - 0 from reset.
  - Rises pSyncStages+1 cycles after Rst deasserts, then stays 1 until the next reset.
  - Flags are still updated while Valid=0; consumers ignore them until Valid=1.
- GrayErr:
  - Compare SyncPtr with its value one cycle earlier; popcount(XOR) > 1 sets GrayErr on the next edge.
  - A change of 0 or 1 bits is legal.
  - The check is gated by Valid so reset flushing is never flagged.
- LevelErr: set when a registered Level update is > D. Level still takes the computed value and is not saturated.
- Both errors are sticky until ErrClr=1. If ErrClr and a new error event occur in the same cycle, set wins.
- Reset mid-operation: immediate return to reset values, including clearing both errors; Valid re-runs the flush count.
- Simultaneous changes: LclPtr and RmtPtr may change in the same cycle. Level uses the values sampled at that edge, with no priority logic.

Test Plan (pAddrSize=3, D=8, pSyncStages=2, pAlmostSize=2):
- Reset release with RmtPtr=0, LclPtr=0, type 0: Valid rises on the 3rd edge; Level=0, AlmostFlag=0. The same run with type 1 gives AlmostFlag=1 throughout.
- Type 0, hold RmtPtr=gray(0), step LclPtr gray 0→6: Level tracks 1..6 with 1-cycle lag; AlmostFlag=1 exactly when Level reaches 6.
- Type 1, wrap: LclPtr=gray(14)=0b1001, RmtPtr steps to gray(1)=0b0001; after 3 cycles SyncBin=1, Level=3, AlmostFlag=0.
- Latency: after Valid, change RmtPtr at edge N; SyncPtr changes at N+2 and SyncBin/Level at N+3.
- Force RmtPtr jump 0b0000→0b0011 after Valid: GrayErr=1 one cycle after SyncPtr shows 0b0011. It holds until ErrClr; pulsing ErrClr in the same cycle as a second bad step leaves GrayErr=1.
- Type 0, LclPtr=gray(9), RmtPtr=gray(0): Level=9, LevelErr=1. Assert Rst mid-run: all outputs return to reset values asynchronously and the errors clear.
